rhs_spi_slave_model: RTL and testbench
======================================

Name: rhs_spi_slave_model

Overview:
- Parametrised, clk-domain behavioural model of an RHS-style stimulation/recording headstage SPI slave, used in simulation and on FPGA loop-back benches.
- Oversamples SCLK, CS and MOSI, and decodes 32-bit MOSI commands (CONVERT, READ, WRITE, CLEAR).
- Generates deterministic per-channel sample patterns and returns each command's result on MISO PIPE_DEPTH frames later, as the real device does.
- Sits between the SPI master under test and the bench scoreboard.

Parameters:
- NUM_CHANNELS, 16, number of convertible channels; valid range 1..64.
- STARTING_SEED, 0, 16-bit offset added to every generated sample.
- PIPE_DEPTH, 2, number of frames between a command and its response; valid range 1..4.
- NUM_REGS, 8, depth of the 16-bit register file; must be a power of 2, maximum 256.

Ports:
- clk  in  1  system clock; must be at least 8x the SCLK frequency.
- rst  in  1  asynchronous, active-high reset.
- SCLK  in  1  SPI clock, asynchronous to clk; idles low (CPOL=0, CPHA=0).
- CS  in  1  SPI chip select, active low, asynchronous.
- MOSI  in  1  SPI data in, MSB first.
- MISO  out  1  SPI data out, MSB first.
- frame_done  out  1  one-clk pulse when a complete 32-bit frame has been executed.
- frame_err  out  1  one-clk pulse when a frame is aborted with a bit count other than 32.
- frame_count  out  16  count of complete frames; wraps modulo 2^16.

Behaviour:
- Input sync: SCLK, CS and MOSI each pass through a 2-FF synchroniser plus one edge-detect register. All three paths have identical delay.
- FSM states:
  - IDLE (CS high). On CS falling: load tx_shift from pipe[PIPE_DEPTH-1], clear bit_cnt, go to SHIFT.
  - SHIFT. On SCLK rising: rx_shift <= {rx_shift[30:0], MOSI}; bit_cnt increments and saturates at 33. On SCLK falling: tx_shift shifts left by 1. On CS rising: go to EXEC if bit_cnt==32, otherwise go to ABORT.
  - EXEC (1 clk). Decode rx_shift; shift pipe (pipe[0] <= response, pipe[i] <= pipe[i-1]); pulse frame_done; increment frame_count; go to IDLE.
  - ABORT (1 clk). Pipe, counters and registers are untouched; go to IDLE.
- MISO = tx_shift[31], registered, so bit 31 is valid before the first SCLK rise. MISO = 0 in IDLE.
- Command decode, rx[31:30]:
  - 00 CONVERT: ch = rx[21:16].
    - If ch < NUM_CHANNELS: response = {sample, 16'h0000}, where sample = ch + STARTING_SEED + (mode_reg[0] ? conv_cnt[ch] : 0), mod 2^16. conv_cnt[ch] then increments and wraps at 2^16.
    - If ch >= NUM_CHANNELS: response = 32'h0000_0000 and no counter changes.
  - 01 CLEAR: all conv_cnt <= 0; response = 32'h0000_0000.
  - 10 WRITE: addr = rx[23:16] mod NUM_REGS; regs[addr] <= rx[15:0]; response = {16'hFFFF, rx[15:0]}.
  - 11 READ: response = {16'h0000, regs[rx[23:16] mod NUM_REGS]}. Register 0 is mode_reg; bit 0 = ramp enable.
- CS rising and an SCLK edge detected in the same clk: the SCLK edge is ignored.
- Reset (any time, including mid-frame): FSM = IDLE; MISO, frame_done, frame_err = 0; frame_count = 0; pipe, tx_shift, rx_shift, regs and conv_cnt = 0. A frame interrupted by reset is lost. The first PIPE_DEPTH responses after reset are 32'h0.

Optional Feature:
- Macro: RHS_SPI_FRAME_ERR_EN.
- When defined: entry to ABORT pulses frame_err for 1 clk, and a 16-bit saturating abort counter is readable through READ at address NUM_REGS-1 (writes to that address are ignored).
- When undefined: frame_err is tied to 0, no abort counter exists, and address NUM_REGS-1 is an ordinary register.

Test Plan:
- Reset, then 3 frames CONVERT ch 5 with SEED=0 and ramp off -> MISO returns 0, 0, then 32'h0005_0000; frame_count = 3.
- WRITE addr 0 data 1 (ramp on), then CONVERT ch 2 x4, then 2 idle frames -> responses show upper 16 bits = 2, 3, 4, 5 starting 2 frames after the first CONVERT; the WRITE echoes 32'hFFFF_0001.
- CONVERT ch 63 with NUM_CHANNELS=16 -> response 32'h0000_0000; a following CONVERT ch 0 with ramp off returns 32'h0000_0000 + SEED<<16 (no counter corruption).
- Frame with only 20 SCLK pulses, then a valid READ addr 0 -> frame_err pulse (macro on), frame_count unchanged by the short frame, pipe not advanced, READ result appears 2 full frames later.
- Assert rst mid-frame after 10 bits -> MISO = 0 within 1 clk, frame_count = 0, next 2 full frames return 32'h0.
- CLEAR after 3 ramped converts on ch 1 -> next CONVERT ch 1 returns sample = 1 + SEED.

Source files
------------

// File: rtl/rhs_spi_slave_model.sv
// Behavioural RHS-style headstage SPI slave (CPOL=0, CPHA=0) that returns each 32-bit command's result PIPE_DEPTH frames later.
// Optional: define RHS_SPI_FRAME_ERR_EN for frame_err pulses and an abort counter read at address NUM_REGS-1.
module rhs_spi_slave_model #(
   parameter int          NUM_CHANNELS  = 16,
   parameter logic [15:0] STARTING_SEED = 16'h0000,
   parameter int          PIPE_DEPTH    = 2,
   parameter int          NUM_REGS      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SCLK,
   input  logic        CS,
   input  logic        MOSI,
   output logic        MISO,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] frame_count
);

   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [6:0]    NCH       = 7'(NUM_CHANNELS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, EXEC, ABORT} state_t;

   state_t      state;
   logic [2:0]  sclk_sr, cs_sr;
   logic [1:0]  mosi_sr;
   logic [31:0] tx_shift, rx_shift;
   logic [5:0]  bit_cnt;
   logic [31:0] pipe [PIPE_DEPTH];
   logic [15:0] regs [2**AW];
   logic [15:0] conv_cnt [2**CW];

   logic          sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic [1:0]    op;
   logic [5:0]    ch;
   logic [CW-1:0] ch_idx;
   logic          ch_valid;
   logic [AW-1:0] addr;
   logic [15:0]   sample, rd_data;
   logic [31:0]   response;
   logic          unused_bits;

`ifdef RHS_SPI_FRAME_ERR_EN
   logic [15:0] abort_cnt;
`endif

   // Edges come from the last sync stage vs. the edge register; MOSI's second stage lines up with them.
   assign sclk_rise   = sclk_sr[1] & ~sclk_sr[2];
   assign sclk_fall   = ~sclk_sr[1] & sclk_sr[2];
   assign cs_fall     = ~cs_sr[1] & cs_sr[2];
   assign cs_rise     = cs_sr[1] & ~cs_sr[2];
   assign unused_bits = &{1'b0, rx_shift[29:16]};

   always_comb begin
      op       = rx_shift[31:30];
      ch       = rx_shift[21:16];
      ch_idx   = ch[CW-1:0];
      ch_valid = ({1'b0, ch} < NCH);
      addr     = rx_shift[16 +: AW];
      sample   = {10'b0, ch} + STARTING_SEED + (regs[0][0] ? conv_cnt[ch_idx] : 16'h0000);
`ifdef RHS_SPI_FRAME_ERR_EN
      rd_data  = (addr == LAST_ADDR) ? abort_cnt : regs[addr];
`else
      rd_data  = regs[addr];
`endif
      response = 32'h0000_0000;
      case (op)
         2'b00:   response = ch_valid ? {sample, 16'h0000} : 32'h0000_0000;
         2'b01:   response = 32'h0000_0000;
         2'b10:   response = {16'hFFFF, rx_shift[15:0]};
         default: response = {16'h0000, rd_data};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sr <= 3'b000;
         cs_sr   <= 3'b111;
         mosi_sr <= 2'b00;
      end else begin
         sclk_sr <= {sclk_sr[1:0], SCLK};
         cs_sr   <= {cs_sr[1:0], CS};
         mosi_sr <= {mosi_sr[0], MOSI};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         MISO        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= 16'h0000;
         tx_shift    <= 32'h0;
         rx_shift    <= 32'h0;
         bit_cnt     <= 6'd0;
         for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= 32'h0;
         for (int i = 0; i < 2**AW; i++) regs[i] <= 16'h0;
         for (int i = 0; i < 2**CW; i++) conv_cnt[i] <= 16'h0;
`ifdef RHS_SPI_FRAME_ERR_EN
         frame_err <= 1'b0;
         abort_cnt <= 16'h0;
`endif
      end else begin
         frame_done <= 1'b0;
`ifdef RHS_SPI_FRAME_ERR_EN
         frame_err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               MISO <= 1'b0;
               if (cs_fall) begin
                  tx_shift <= pipe[PIPE_DEPTH-1];
                  MISO     <= pipe[PIPE_DEPTH-1][31];
                  bit_cnt  <= 6'd0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               // CS rising wins over any SCLK edge seen in the same cycle.
               if (cs_rise) begin
                  MISO  <= 1'b0;
                  state <= (bit_cnt == 6'd32) ? EXEC : ABORT;
`ifdef RHS_SPI_FRAME_ERR_EN
                  frame_err <= (bit_cnt != 6'd32);
`endif
               end else begin
                  if (sclk_rise) begin
                     rx_shift <= {rx_shift[30:0], mosi_sr[1]};
                     if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
                  end
                  if (sclk_fall) begin
                     tx_shift <= {tx_shift[30:0], 1'b0};
                     MISO     <= tx_shift[30];
                  end
               end
            end
            EXEC: begin
               pipe[0] <= response;
               for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
               frame_done  <= 1'b1;
               frame_count <= frame_count + 16'd1;
               case (op)
                  2'b00: if (ch_valid) conv_cnt[ch_idx] <= conv_cnt[ch_idx] + 16'd1;
                  2'b01: for (int i = 0; i < 2**CW; i++) conv_cnt[i] <= 16'h0;
                  2'b10: begin
`ifdef RHS_SPI_FRAME_ERR_EN
                     if (addr != LAST_ADDR) regs[addr] <= rx_shift[15:0];
`else
                     regs[addr] <= rx_shift[15:0];
`endif
                  end
                  default: ;
               endcase
               state <= IDLE;
            end
            default: begin
`ifdef RHS_SPI_FRAME_ERR_EN
               if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
`endif
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef RHS_SPI_FRAME_ERR_EN
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_rhs_spi_slave_model.sv
// Bench for rhs_spi_slave_model: table of {command, response} frames plus hand-written short-frame and mid-frame-reset sequences.
module tb_rhs_spi_slave_model;

   localparam int PD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        SCLK = 1'b0;
   logic        CS = 1'b1;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic        frame_done;
   logic        frame_err;
   logic [15:0] frame_count;

   typedef struct {
      logic [31:0] cmd;
      logic [31:0] resp;
   } vec_t;

   vec_t        vecs[32];
   int          nvec = 0;
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_frames = 0;
   int          done_seen = 0;
   int          err_seen = 0;
   int          done_base = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   rhs_spi_slave_model #(
      .NUM_CHANNELS(16), .STARTING_SEED(16'h0000), .PIPE_DEPTH(PD), .NUM_REGS(8)
   ) dut (
      .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
      .MISO(MISO), .frame_done(frame_done), .frame_err(frame_err), .frame_count(frame_count)
   );

   always @(negedge clk) begin
      if (frame_done) done_seen++;
      if (frame_err) err_seen++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] cmd, input logic [31:0] resp);
      vecs[nvec].cmd  = cmd;
      vecs[nvec].resp = resp;
      nvec++;
   endtask

   task automatic spi_frame(input logic [31:0] w, input int nbits, output logic [31:0] r);
      r  = 32'h0;
      CS = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         MOSI = w[31-i];
         repeat (4) @(negedge clk);
         r[31-i] = MISO;
         SCLK = 1'b1;
         repeat ($urandom_range(6, 9)) @(negedge clk);
         SCLK = 1'b0;
         repeat (4) @(negedge clk);
      end
      CS = 1'b1;
      repeat (8) @(negedge clk);
      if (nbits == 32) exp_frames++;
   endtask

   task automatic run_vec(input int idx);
      logic [31:0] exp;
      spi_frame(vecs[idx].cmd, 32, rd);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty[%0d]: got no entry expected one", idx);
      end else begin
         exp = exp_q.pop_front();
         check($sformatf("miso[%0d]", idx), rd, exp);
      end
      exp_q.push_back(vecs[idx].resp);
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) run_vec(i);
   endtask

   task automatic after_reset();
      exp_q.delete();
      for (int i = 0; i < PD; i++) exp_q.push_back(32'h0);
      exp_frames = 0;
      done_base  = done_seen;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_frame_count"}, {16'h0, frame_count}, 32'(exp_frames));
      check({tag, "_done_pulses"}, 32'(done_seen - done_base), 32'(exp_frames));
   endtask

   initial begin
      // Segment A: ramp-off converts, ramp-on converts, out-of-range channel, register modulo addressing.
      add(32'h0005_0000, 32'h0005_0000);
      add(32'h0005_0000, 32'h0005_0000);
      add(32'h0005_0000, 32'h0005_0000);
      add(32'h8000_0001, 32'hFFFF_0001);
      add(32'h0002_0000, 32'h0002_0000);
      add(32'h0002_0000, 32'h0003_0000);
      add(32'h0002_0000, 32'h0004_0000);
      add(32'h0002_0000, 32'h0005_0000);
      add(32'hC001_0000, 32'h0000_0000);
      add(32'hC001_0000, 32'h0000_0000);
      add(32'h8000_0000, 32'hFFFF_0000);
      add(32'h003F_0000, 32'h0000_0000);
      add(32'h0000_0000, 32'h0000_0000);
      add(32'h8000_0001, 32'hFFFF_0001);
      add(32'h000F_0000, 32'h000F_0000);
      add(32'h0000_0000, 32'h0001_0000);
      add(32'h800B_BEEF, 32'hFFFF_BEEF);
      add(32'hC003_0000, 32'h0000_BEEF);
      // Segment B (after a short frame): read-back, top address, CLEAR after ramped converts.
      add(32'hC000_0000, 32'h0000_0001);
`ifdef RHS_SPI_FRAME_ERR_EN
      add(32'hC007_0000, 32'h0000_0001);
`else
      add(32'hC007_0000, 32'h0000_0000);
`endif
      add(32'h0001_0000, 32'h0001_0000);
      add(32'h0001_0000, 32'h0002_0000);
      add(32'h0001_0000, 32'h0003_0000);
      add(32'h4000_0000, 32'h0000_0000);
      add(32'h0001_0000, 32'h0001_0000);
      add(32'h8002_FFFF, 32'hFFFF_FFFF);
      add(32'hC002_0000, 32'h0000_FFFF);
      // Segment C (after mid-frame reset): registers must read back cleared.
      add(32'hC002_0000, 32'h0000_0000);
      add(32'hC002_0000, 32'h0000_0000);
      add(32'hC000_0000, 32'h0000_0000);

      // Clock/reset
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      after_reset();
      repeat (4) @(negedge clk);
      check("reset_miso", {31'h0, MISO}, 32'h0);
      check("reset_frame_count", {16'h0, frame_count}, 32'h0);
      check("reset_frame_done", {31'h0, frame_done}, 32'h0);
      check("reset_frame_err", {31'h0, frame_err}, 32'h0);

      run_range(0, 2);
      check_counts("convert_x3");
      run_range(3, 17);
      check_counts("seg_a");

      // Short frame: 20 clocks, must not advance pipe or frame_count.
      begin
         int err_before;
         err_before = err_seen;
         spi_frame(32'hC000_0000, 20, rd);
         check_counts("short_frame");
`ifdef RHS_SPI_FRAME_ERR_EN
         check("short_frame_err_pulses", 32'(err_seen - err_before), 32'd1);
`else
         check("short_frame_err_pulses", 32'(err_seen - err_before), 32'd0);
`endif
      end

      run_range(18, 26);
      check_counts("seg_b");

      // Mid-frame reset after 10 bits of a frame shifting out 32'hFFFF_FFFF.
      CS = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         MOSI = 1'b1;
         repeat (4) @(negedge clk);
         SCLK = 1'b1;
         repeat (8) @(negedge clk);
         SCLK = 1'b0;
         repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("miso_before_reset", {31'h0, MISO}, 32'h1);
      rst = 1'b1;
      #1;
      check("miso_in_reset", {31'h0, MISO}, 32'h0);
      check("frame_count_in_reset", {16'h0, frame_count}, 32'h0);
      CS   = 1'b1;
      SCLK = 1'b0;
      MOSI = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      after_reset();
      repeat (4) @(negedge clk);

      run_range(27, 29);
      check_counts("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
